// File: rtl/intdiv_sd2_to_bin.sv
// intdiv_sd2_to_bin: serial MSB-first SD2 -> two's-complement converter.
// One SD2 magnitude digit is accepted per handshake. The SD2 sign is sampled
// with the first digit of each operand. On-the-fly conversion keeps the pair
// Q / QM = Q-1, so no carry-propagate adder is needed.
// Optional feature macro: INTDIV_S2B_ZERO_FLAG_EN adds the registered out_zero flag.
module intdiv_sd2_to_bin #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [1:0]   in_digit,
    input  logic [1:0]   sign,
    output logic         out_valid,
    input  logic         out_ready,
`ifdef INTDIV_S2B_ZERO_FLAG_EN
    output logic         out_zero,
`endif
    output logic [N:0]   out_value
);

    localparam int W  = N + 1;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SD_ZERO = 2'b00;
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;

    logic [1:0]    state;
    logic [W-1:0]  q;
    logic [W-1:0]  qm;
    logic [CW-1:0] count;
    logic [1:0]    sign_reg;

    logic          accept;
    logic [1:0]    sign_use;
    logic          d_pos;
    logic          d_neg;
    logic [W-1:0]  q_base;
    logic [W-1:0]  qm_base;
    logic [W-1:0]  q_next;
    logic [W-1:0]  qm_next;

    assign in_ready = (state != S_DONE);
    assign accept   = in_valid & in_ready;

    // Effective digit after applying the operand sign, then on-the-fly Q/QM update.
    // A first digit restarts from Q=0 / QM=-1 and uses the incoming sign.
    always_comb begin
        sign_use = in_first ? sign : sign_reg;
        d_pos    = 1'b0;
        d_neg    = 1'b0;
        case (sign_use)
            SD_POS: begin
                d_pos = in_digit[1] & ~in_digit[0];
                d_neg = in_digit[0] & ~in_digit[1];
            end
            SD_NEG: begin
                d_pos = in_digit[0] & ~in_digit[1];
                d_neg = in_digit[1] & ~in_digit[0];
            end
            default: begin
                d_pos = 1'b0;
                d_neg = 1'b0;
            end
        endcase

        q_base  = in_first ? '0 : q;
        qm_base = in_first ? '1 : qm;

        if (d_pos) begin
            q_next  = {q_base[W-2:0], 1'b1};
            qm_next = {q_base[W-2:0], 1'b0};
        end else if (d_neg) begin
            q_next  = {qm_base[W-2:0], 1'b1};
            qm_next = {qm_base[W-2:0], 1'b0};
        end else begin
            q_next  = {q_base[W-2:0], 1'b0};
            qm_next = {qm_base[W-2:0], 1'b1};
        end
    end

    // Control FSM, digit accumulation and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            q         <= '0;
            qm        <= '1;
            count     <= '0;
            sign_reg  <= SD_ZERO;
            out_valid <= 1'b0;
            out_value <= '0;
`ifdef INTDIV_S2B_ZERO_FLAG_EN
            out_zero  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    // Digits without in_first are dropped here.
                    if (accept && in_first) begin
                        q        <= q_next;
                        qm       <= qm_next;
                        sign_reg <= sign;
                        count    <= CW'(1);
                        state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        q  <= q_next;
                        qm <= qm_next;
                        if (in_first) begin
                            sign_reg <= sign;
                            count    <= CW'(1);
                        end else if (count == CNT_LAST) begin
                            count     <= count + CW'(1);
                            out_value <= q_next;
                            out_valid <= 1'b1;
`ifdef INTDIV_S2B_ZERO_FLAG_EN
                            out_zero  <= (q_next == '0);
`endif
                            state     <= S_DONE;
                        end else begin
                            count <= count + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_sd2_to_bin.sv
// tb_intdiv_sd2_to_bin: directed and randomized checks of the SD2 -> binary
// converter (N=4) against an arithmetic reference model.
module tb_intdiv_sd2_to_bin;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [1:0]   in_digit;
    logic [1:0]   sign;
    logic         out_valid;
    logic         out_ready;
    logic [N:0]   out_value;
`ifdef INTDIV_S2B_ZERO_FLAG_EN
    logic         out_zero;
`endif

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    intdiv_sd2_to_bin #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_digit  (in_digit),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef INTDIV_S2B_ZERO_FLAG_EN
        .out_zero  (out_zero),
`endif
        .out_value (out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value of one SD2 code: 10 -> +1, 01 -> -1, 00/11 -> 0.
    function automatic int sd_val(input logic [1:0] c);
        if (c == 2'b10) return 1;
        if (c == 2'b01) return -1;
        return 0;
    endfunction

    // Reference: signed value = sign * sum(d_i * 2^(N-1-i)), truncated to N+1 bits.
    function automatic logic [N:0] ref_result(input logic [1:0] sg, input logic [1:0] d [N]);
        int v = 0;
        for (int i = 0; i < N; i++) v = v * 2 + sd_val(d[i]);
        v = v * sd_val(sg);
        return v[N:0];
    endfunction

    // Present one digit; waits (bounded) for in_ready, returns #1 after the accepting edge.
    task automatic send(input logic first, input logic [1:0] dig, input logic [1:0] sg, input int unsigned gap);
        int unsigned guard = 0;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_first = first;
        in_digit = dig;
        sign     = sg;
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_digit = $urandom_range(0, 3);
        sign     = $urandom_range(0, 3);
    endtask

    // Full operand: checks no early result, 1-cycle latency, value, hold while
    // out_ready=0, then release to IDLE.
    task automatic run_operand(input string tag, input logic [1:0] sg, input logic [1:0] d [N],
                               input int unsigned max_gap, input int unsigned hold);
        logic [N:0] exp;
        exp = ref_result(sg, d);
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            send(i == 0, d[i], sg, $urandom_range(0, max_gap));
            if (i < N - 1) check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_value"}, 32'(out_value), 32'(exp));
`ifdef INTDIV_S2B_ZERO_FLAG_EN
        check({tag, "_zero"}, 32'(out_zero), 32'(exp == '0));
`endif
        for (int c = 0; c < int'(hold); c++) begin
            // Inputs offered during DONE must be ignored.
            in_valid = 1'b1;
            in_first = $urandom_range(0, 1);
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_value"}, 32'(out_value), 32'(exp));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_first  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_release_value"}, 32'(out_value), 32'(exp));
    endtask

    task automatic apply_async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_rst_value"}, 32'(out_value), 32'd0);
        check({tag, "_rst_ready"}, 32'(in_ready), 32'd1);
`ifdef INTDIV_S2B_ZERO_FLAG_EN
        check({tag, "_rst_zero"}, 32'(out_zero), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] d [N];
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_digit  = 2'b00;
        sign      = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_value", 32'(out_value), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors from the plan.
        d = '{2'b10, 2'b00, 2'b01, 2'b10};
        run_operand("pos7", 2'b10, d, 0, 0);
        check("pos7_const", 32'(out_value), 32'h07);
        run_operand("neg7", 2'b01, d, 0, 5);
        check("neg7_const", 32'(out_value), 32'h19);
        d = '{2'b01, 2'b10, 2'b10, 2'b10};
        run_operand("m1", 2'b10, d, 1, 1);
        check("m1_const", 32'(out_value), 32'h1f);
        d = '{2'b10, 2'b10, 2'b10, 2'b10};
        run_operand("p15", 2'b10, d, 0, 0);
        check("p15_const", 32'(out_value), 32'h0f);
        run_operand("sign11", 2'b11, d, 0, 0);
        check("sign11_const", 32'(out_value), 32'h00);
        d = '{2'b11, 2'b00, 2'b10, 2'b01};
        run_operand("mixz", 2'b10, d, 0, 2);
        check("mixz_const", 32'(out_value), 32'h01);

        // Digits without in_first in IDLE are dropped.
        send(1'b0, 2'b10, 2'b10, 0);
        send(1'b0, 2'b01, 2'b01, 0);
        send(1'b0, 2'b10, 2'b10, 0);
        check("drop_no_valid", 32'(out_valid), 32'd0);
        d = '{2'b00, 2'b01, 2'b00, 2'b10};
        run_operand("after_drop", 2'b10, d, 0, 0);

        // Restart: two digits of a discarded operand, then a full operand.
        send(1'b1, 2'b10, 2'b01, 0);
        send(1'b0, 2'b10, 2'b01, 0);
        d = '{2'b01, 2'b00, 2'b10, 2'b10};
        run_operand("restart", 2'b10, d, 0, 0);

        // Async reset mid-ACCUM and mid-DONE, then a clean operand.
        send(1'b1, 2'b10, 2'b10, 0);
        send(1'b0, 2'b10, 2'b10, 0);
        apply_async_reset("mid_accum");
        d = '{2'b10, 2'b10, 2'b10, 2'b01};
        for (int i = 0; i < N; i++) send(i == 0, d[i], 2'b10, 0);
        check("pre_done_valid", 32'(out_valid), 32'd1);
        apply_async_reset("mid_done");
        d = '{2'b10, 2'b01, 2'b01, 2'b00};
        run_operand("post_reset", 2'b01, d, 0, 0);

        // Randomized operands with input gaps and output backpressure.
        for (int t = 0; t < 40; t++) begin
            logic [1:0] sg;
            sg = $urandom_range(0, 3);
            if ($urandom_range(0, 3) != 0) sg = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
            for (int i = 0; i < N; i++) d[i] = $urandom_range(0, 3);
            run_operand("rand", sg, d, 2, $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
